banco_contadores_transicion: RTL and testbench

- Clocked, parametrised bank of per-channel transition counters for switching-activity and power estimation of adder instances.
- Each of NUM_CANALES 1-bit monitored signals is sampled every clk; each sampled toggle increments that channel's counter.
- Counting runs only inside a start/stop window.
- Counters are preloaded, cleared and read through separate, unidirectional, address-based write and read ports (no tri-state bus).

---
 rtl/banco_contadores_transicion.sv | 141 ++++++++++++++
 tb/tb_banco_contadores_transicion.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_contadores_transicion.sv
// Bank of per-channel transition counters with start/stop window and address-based preload/read ports.
// Optional feature: define CONTADOR_SATURACION_EN to saturate counters at all-ones instead of wrapping.
module banco_contadores_transicion #(
   parameter int NUM_CANALES = 3,
   parameter int ANCHO       = 32,
   parameter int ANCHO_DIR   = 2
) (
   input  logic                   clk,
   input  logic                   reset_L,
   input  logic [NUM_CANALES-1:0] senal,
   input  logic                   iniciar,
   input  logic                   detener,
   input  logic                   borrar,
   input  logic                   esc,
   input  logic [ANCHO_DIR-1:0]   esc_dir,
   input  logic [ANCHO-1:0]       esc_dato,
   input  logic                   lee,
   input  logic [ANCHO_DIR-1:0]   lee_dir,
   output logic [ANCHO-1:0]       lee_dato,
   output logic                   lee_valido,
   output logic [NUM_CANALES-1:0] desborde,
   output logic                   contando
);

   typedef enum logic [1:0] {
      REPOSO,
      CONTANDO,
      DETENIDO
   } estado_t;

   estado_t                estado_q;
   logic                   contando_q;
   logic [NUM_CANALES-1:0] senal_prev_q;
   logic [ANCHO-1:0]       cnt_q [NUM_CANALES];
   logic [ANCHO-1:0]       cnt_d [NUM_CANALES];
   logic [NUM_CANALES-1:0] desborde_q;
   logic [NUM_CANALES-1:0] desborde_d;
   logic [ANCHO-1:0]       lee_dato_q;
   logic [ANCHO-1:0]       lee_dato_d;
   logic                   lee_valido_q;

   // detener dominates iniciar, so a simultaneous pair never opens the window.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         estado_q   <= REPOSO;
         contando_q <= 1'b0;
      end else if (borrar) begin
         estado_q   <= REPOSO;
         contando_q <= 1'b0;
      end else begin
         case (estado_q)
            REPOSO: begin
               if (iniciar && !detener) begin
                  estado_q   <= CONTANDO;
                  contando_q <= 1'b1;
               end
            end
            CONTANDO: begin
               if (detener) begin
                  estado_q   <= DETENIDO;
                  contando_q <= 1'b0;
               end
            end
            DETENIDO: begin
               if (iniciar && !detener) begin
                  estado_q   <= CONTANDO;
                  contando_q <= 1'b1;
               end
            end
            default: begin
               estado_q   <= REPOSO;
               contando_q <= 1'b0;
            end
         endcase
      end
   end

   // Per-channel priority: clear, then preload, then counted toggle.
   always_comb begin
      cnt_d      = cnt_q;
      desborde_d = desborde_q;
      for (int i = 0; i < NUM_CANALES; i++) begin
         if (borrar) begin
            cnt_d[i]      = '0;
            desborde_d[i] = 1'b0;
         end else if (esc && (esc_dir == ANCHO_DIR'(i))) begin
            cnt_d[i] = esc_dato;
         end else if ((estado_q == CONTANDO) && (senal[i] ^ senal_prev_q[i])) begin
            if (cnt_q[i] == '1) begin
               desborde_d[i] = 1'b1;
`ifdef CONTADOR_SATURACION_EN
               cnt_d[i] = '1;
`else
               cnt_d[i] = '0;
`endif
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Reads see the pre-update counter; unmatched addresses fall through to zero.
   always_comb begin
      lee_dato_d = lee_dato_q;
      if (lee) begin
         lee_dato_d = '0;
         for (int i = 0; i < NUM_CANALES; i++) begin
            if (lee_dir == ANCHO_DIR'(i)) begin
               lee_dato_d = cnt_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         senal_prev_q <= '0;
         desborde_q   <= '0;
         lee_dato_q   <= '0;
         lee_valido_q <= 1'b0;
         for (int i = 0; i < NUM_CANALES; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         senal_prev_q <= senal;
         desborde_q   <= desborde_d;
         lee_dato_q   <= lee_dato_d;
         lee_valido_q <= lee;
         for (int i = 0; i < NUM_CANALES; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign lee_dato   = lee_dato_q;
   assign lee_valido = lee_valido_q;
   assign desborde   = desborde_q;
   assign contando   = contando_q;

endmodule

// File: tb/tb_banco_contadores_transicion.sv
// Directed self-checking bench for banco_contadores_transicion (default parameters).
// Overflow expectations follow CONTADOR_SATURACION_EN when that macro is defined for the build.
module tb_banco_contadores_transicion;

   logic        clk;
   logic        reset_L;
   logic [2:0]  senal;
   logic        iniciar;
   logic        detener;
   logic        borrar;
   logic        esc;
   logic [1:0]  esc_dir;
   logic [31:0] esc_dato;
   logic        lee;
   logic [1:0]  lee_dir;
   logic [31:0] lee_dato;
   logic        lee_valido;
   logic [2:0]  desborde;
   logic        contando;

   int passCount;
   int totalCount;

   logic [31:0] rdData;
   logic        rdValid;

   banco_contadores_transicion #(
      .NUM_CANALES(3),
      .ANCHO(32),
      .ANCHO_DIR(2)
   ) dut (
      .clk(clk),
      .reset_L(reset_L),
      .senal(senal),
      .iniciar(iniciar),
      .detener(detener),
      .borrar(borrar),
      .esc(esc),
      .esc_dir(esc_dir),
      .esc_dato(esc_dato),
      .lee(lee),
      .lee_dir(lee_dir),
      .lee_dato(lee_dato),
      .lee_valido(lee_valido),
      .desborde(desborde),
      .contando(contando)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got running, need finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_borrar();
      borrar = 1'b1;
      tick();
      borrar = 1'b0;
   endtask

   task automatic pulse_iniciar();
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
   endtask

   task automatic pulse_detener();
      detener = 1'b1;
      tick();
      detener = 1'b0;
   endtask

   task automatic write_ch(input logic [1:0] dir, input logic [31:0] dato);
      esc      = 1'b1;
      esc_dir  = dir;
      esc_dato = dato;
      tick();
      esc      = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] dir, output logic [31:0] d, output logic v);
      lee     = 1'b1;
      lee_dir = dir;
      tick();
      d       = lee_dato;
      v       = lee_valido;
      lee     = 1'b0;
   endtask

   task automatic test_reset();
      reset_L  = 1'b1;
      senal    = 3'b000;
      iniciar  = 1'b0;
      detener  = 1'b0;
      borrar   = 1'b0;
      esc      = 1'b0;
      esc_dir  = 2'd0;
      esc_dato = 32'd0;
      lee      = 1'b0;
      lee_dir  = 2'd0;
      #1 reset_L = 1'b0;
      #1;
      totalCount++;
      if ({contando, lee_valido, desborde, lee_dato} !== 37'd0) begin
         $display("[TB] FAIL reset_outputs: got %h, need 0", {contando, lee_valido, desborde, lee_dato});
      end else passCount++;
      tick();
      tick();
      reset_L = 1'b1;
      tick();
      totalCount++;
      if (contando !== 1'b0) begin
         $display("[TB] FAIL reset_contando: got %b, need 0", contando);
      end else passCount++;
   endtask

   task automatic test_no_window();
      senal = 3'b000;
      tick();
      senal = 3'b111;
      tick();
      senal = 3'b000;
      tick();
      for (int c = 0; c < 3; c++) begin
         do_read(2'(c), rdData, rdValid);
         totalCount++;
         if (rdData !== 32'd0 || rdValid !== 1'b1) begin
            $display("[TB] FAIL no_window_ch%0d: got %0d valid %b, need 0 valid 1", c, rdData, rdValid);
         end else passCount++;
      end
      totalCount++;
      if (contando !== 1'b0) begin
         $display("[TB] FAIL no_window_contando: got %b, need 0", contando);
      end else passCount++;
   endtask

   task automatic test_window();
      pulse_iniciar();
      totalCount++;
      if (contando !== 1'b1) begin
         $display("[TB] FAIL window_contando_on: got %b, need 1", contando);
      end else passCount++;
      for (int k = 0; k < 10; k++) begin
         senal[0] = ~senal[0];
         if (k == 0) senal[2] = 1'b1;
         tick();
      end
      pulse_detener();
      totalCount++;
      if (contando !== 1'b0) begin
         $display("[TB] FAIL window_contando_off: got %b, need 0", contando);
      end else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] expVals [3];
      expVals[0] = 32'd10;
      expVals[1] = 32'd0;
      expVals[2] = 32'd1;
      lee = 1'b1;
      for (int c = 0; c < 3; c++) begin
         lee_dir = 2'(c);
         tick();
         totalCount++;
         if (lee_dato !== expVals[c] || lee_valido !== 1'b1) begin
            $display("[TB] FAIL window_read_ch%0d: got %0d valid %b, need %0d valid 1", c, lee_dato, lee_valido, expVals[c]);
         end else passCount++;
      end
      lee = 1'b0;
      tick();
      totalCount++;
      if (lee_valido !== 1'b0) begin
         $display("[TB] FAIL valid_single_cycle: got %b, need 0", lee_valido);
      end else passCount++;
   endtask

   task automatic test_resume();
      pulse_iniciar();
      senal[2] = ~senal[2];
      tick();
      pulse_detener();
      do_read(2'd2, rdData, rdValid);
      totalCount++;
      if (rdData !== 32'd2) begin
         $display("[TB] FAIL resume_ch2: got %0d, need 2", rdData);
      end else passCount++;
   endtask

   task automatic test_overflow();
      logic [31:0] expOv;
`ifdef CONTADOR_SATURACION_EN
      expOv = 32'hFFFF_FFFF;
`else
      expOv = 32'd1;
`endif
      pulse_borrar();
      totalCount++;
      if (desborde !== 3'b000 || contando !== 1'b0) begin
         $display("[TB] FAIL overflow_clear: got desborde %b contando %b, need 000 0", desborde, contando);
      end else passCount++;
      write_ch(2'd1, 32'hFFFF_FFFE);
      pulse_iniciar();
      senal[1] = ~senal[1];
      tick();
      totalCount++;
      if (desborde !== 3'b000) begin
         $display("[TB] FAIL overflow_early: got %b, need 000", desborde);
      end else passCount++;
      for (int k = 0; k < 2; k++) begin
         senal[1] = ~senal[1];
         tick();
      end
      totalCount++;
      if (desborde !== 3'b010) begin
         $display("[TB] FAIL overflow_flag: got %b, need 010", desborde);
      end else passCount++;
      pulse_detener();
      do_read(2'd1, rdData, rdValid);
      totalCount++;
      if (rdData !== expOv) begin
         $display("[TB] FAIL overflow_value: got %h, need %h", rdData, expOv);
      end else passCount++;
   endtask

   task automatic test_conflicts();
      pulse_borrar();
      pulse_iniciar();
      esc      = 1'b1;
      esc_dir  = 2'd0;
      esc_dato = 32'd100;
      senal[0] = ~senal[0];
      tick();
      esc = 1'b0;
      pulse_detener();
      do_read(2'd0, rdData, rdValid);
      totalCount++;
      if (rdData !== 32'd100) begin
         $display("[TB] FAIL write_beats_toggle: got %0d, need 100", rdData);
      end else passCount++;

      pulse_borrar();
      iniciar = 1'b1;
      detener = 1'b1;
      tick();
      iniciar = 1'b0;
      detener = 1'b0;
      totalCount++;
      if (contando !== 1'b0) begin
         $display("[TB] FAIL iniciar_detener_together: got %b, need 0", contando);
      end else passCount++;
      senal[0] = ~senal[0];
      tick();
      do_read(2'd0, rdData, rdValid);
      totalCount++;
      if (rdData !== 32'd0) begin
         $display("[TB] FAIL no_count_after_pair: got %0d, need 0", rdData);
      end else passCount++;

      esc      = 1'b1;
      esc_dir  = 2'd1;
      esc_dato = 32'd55;
      lee      = 1'b1;
      lee_dir  = 2'd1;
      tick();
      esc = 1'b0;
      lee = 1'b0;
      totalCount++;
      if (lee_dato !== 32'd0 || lee_valido !== 1'b1) begin
         $display("[TB] FAIL read_write_same: got %0d valid %b, need 0 valid 1", lee_dato, lee_valido);
      end else passCount++;
      do_read(2'd1, rdData, rdValid);
      totalCount++;
      if (rdData !== 32'd55) begin
         $display("[TB] FAIL write_landed: got %0d, need 55", rdData);
      end else passCount++;

      borrar  = 1'b1;
      lee     = 1'b1;
      lee_dir = 2'd1;
      tick();
      borrar = 1'b0;
      lee    = 1'b0;
      totalCount++;
      if (lee_dato !== 32'd55) begin
         $display("[TB] FAIL read_with_borrar: got %0d, need 55", lee_dato);
      end else passCount++;
      tick();
      totalCount++;
      if (lee_dato !== 32'd55 || lee_valido !== 1'b0) begin
         $display("[TB] FAIL lee_dato_held: got %0d valid %b, need 55 valid 0", lee_dato, lee_valido);
      end else passCount++;
      do_read(2'd1, rdData, rdValid);
      totalCount++;
      if (rdData !== 32'd0) begin
         $display("[TB] FAIL cleared_after_borrar: got %0d, need 0", rdData);
      end else passCount++;
   endtask

   task automatic test_out_of_range();
      logic [31:0] expVals [3];
      expVals[0] = 32'd7;
      expVals[1] = 32'd8;
      expVals[2] = 32'd9;
      for (int c = 0; c < 3; c++) write_ch(2'(c), expVals[c]);
      do_read(2'd3, rdData, rdValid);
      totalCount++;
      if (rdData !== 32'd0 || rdValid !== 1'b1) begin
         $display("[TB] FAIL oor_read: got %0d valid %b, need 0 valid 1", rdData, rdValid);
      end else passCount++;
      write_ch(2'd3, 32'hDEAD);
      for (int c = 0; c < 3; c++) begin
         do_read(2'(c), rdData, rdValid);
         totalCount++;
         if (rdData !== expVals[c]) begin
            $display("[TB] FAIL oor_write_ch%0d: got %0d, need %0d", c, rdData, expVals[c]);
         end else passCount++;
      end
   endtask

   task automatic test_mid_window();
      write_ch(2'd2, 32'hFFFF_FFFF);
      write_ch(2'd0, 32'd42);
      pulse_iniciar();
      senal[2] = ~senal[2];
      tick();
      totalCount++;
      if (desborde !== 3'b100) begin
         $display("[TB] FAIL mid_desborde_set: got %b, need 100", desborde);
      end else passCount++;
      senal[0] = ~senal[0];
      tick();
      pulse_borrar();
      totalCount++;
      if (contando !== 1'b0 || desborde !== 3'b000) begin
         $display("[TB] FAIL mid_borrar: got contando %b desborde %b, need 0 000", contando, desborde);
      end else passCount++;
      senal[0] = ~senal[0];
      tick();
      do_read(2'd0, rdData, rdValid);
      totalCount++;
      if (rdData !== 32'd0) begin
         $display("[TB] FAIL mid_borrar_ch0: got %0d, need 0", rdData);
      end else passCount++;

      write_ch(2'd2, 32'hFFFF_FFFF);
      write_ch(2'd0, 32'd42);
      pulse_iniciar();
      senal[2] = ~senal[2];
      tick();
      lee     = 1'b1;
      lee_dir = 2'd0;
      tick();
      totalCount++;
      if (lee_dato !== 32'd42 || lee_valido !== 1'b1 || contando !== 1'b1 || desborde !== 3'b100) begin
         $display("[TB] FAIL pre_reset_state: got %0d %b %b %b, need 42 1 1 100", lee_dato, lee_valido, contando, desborde);
      end else passCount++;
      #2 reset_L = 1'b0;
      #1;
      totalCount++;
      if ({contando, lee_valido, desborde, lee_dato} !== 37'd0) begin
         $display("[TB] FAIL async_reset: got %h, need 0", {contando, lee_valido, desborde, lee_dato});
      end else passCount++;
      lee = 1'b0;
      #1 reset_L = 1'b1;
      tick();
      do_read(2'd0, rdData, rdValid);
      totalCount++;
      if (rdData !== 32'd0 || contando !== 1'b0) begin
         $display("[TB] FAIL post_reset_ch0: got %0d contando %b, need 0 0", rdData, contando);
      end else passCount++;
   endtask

   initial begin
      passCount  = 0;
      totalCount = 0;
      test_reset();
      test_no_window();
      test_window();
      test_back_to_back();
      test_resume();
      test_overflow();
      test_conflicts();
      test_out_of_range();
      test_mid_window();
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
